// File: rtl/xoodoo_rdi_buffer_pkg.sv
// xoodoo_rdi_buffer_pkg: shared widths and whitening LFSR constants for the
// Xoodoo mask-randomness buffer.
package xoodoo_rdi_buffer_pkg;
   localparam int XOODOO_STATE_W = 384;
   localparam int RDI_BLOCK_W = 768;
   localparam logic [63:0] RDI_LFSR_SEED = 64'h9E37_79B9_7F4A_7C15;
   // Fibonacci taps 64,63,61,60 as state bits 63,62,60,59
   localparam logic [63:0] RDI_LFSR_TAPS = 64'hD800_0000_0000_0000;
   function automatic logic [63:0] lfsr_next(input logic [63:0] s);
      return {s[62:0], ^(s & RDI_LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/xoodoo_rdi_buffer_if.sv
// xoodoo_rdi_buffer_if: random-word input, mask-block output and flush
// signals of the buffer; slave = buffer side, master = source/core side.
interface xoodoo_rdi_buffer_if
   import xoodoo_rdi_buffer_pkg::*;
   #(parameter int RND_W = 64);
   logic flush_i;
   logic [RND_W-1:0] rnd_i;
   logic rnd_valid_i;
   logic rnd_ready_o;
   logic [XOODOO_STATE_W-1:0] rs0_o;
   logic [XOODOO_STATE_W-1:0] rs1_o;
   logic rdi_valid_o;
   logic rdi_ready_i;
   logic [3:0] fill_level_o;
   modport slave (input flush_i, rnd_i, rnd_valid_i, rdi_ready_i,
                  output rnd_ready_o, rs0_o, rs1_o, rdi_valid_o, fill_level_o);
   modport master (output flush_i, rnd_i, rnd_valid_i, rdi_ready_i,
                   input rnd_ready_o, rs0_o, rs1_o, rdi_valid_o, fill_level_o);
endinterface

// File: rtl/xoodoo_rdi_lfsr.sv
// xoodoo_rdi_lfsr: 64-bit Fibonacci whitening LFSR, one step per accepted
// word; reset and flush restore the seed.
module xoodoo_rdi_lfsr
   import xoodoo_rdi_buffer_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        step_i,
   output logic [63:0] state_o
);
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_o <= RDI_LFSR_SEED;
      else if (flush_i) state_o <= RDI_LFSR_SEED;
      else if (step_i) state_o <= lfsr_next(state_o);
endmodule

// File: rtl/xoodoo_rdi_buffer.sv
// xoodoo_rdi_buffer: packs RND_W-bit random words into 768-bit two-share mask
// blocks for the Xoodoo core; whitening via RDI_LFSR_WHITEN_EN.
module xoodoo_rdi_buffer
   import xoodoo_rdi_buffer_pkg::*;
   #(parameter int RND_W = 64)
(
   input logic clk_i,
   input logic rst_ni,
   xoodoo_rdi_buffer_if.slave bus
);
   localparam int NW = RDI_BLOCK_W / RND_W;
   localparam logic [3:0] NW_L = 4'(NW);
   if (RDI_BLOCK_W % RND_W != 0 || NW > 15) begin : g_bad_w
      $error("RND_W must divide 768 into at most 15 words");
   end
   logic [RDI_BLOCK_W-1:0] fill_q;
   logic [RDI_BLOCK_W-1:0] out_q;
   logic [3:0] cnt_q;
   logic valid_q;
   logic accept;
   logic transfer;
   logic consume;
   logic [RND_W-1:0] word;
   assign bus.rnd_ready_o = (cnt_q < NW_L) && !bus.flush_i;
   assign accept = bus.rnd_valid_i && bus.rnd_ready_o;
   assign transfer = (cnt_q == NW_L) && (!valid_q || bus.rdi_ready_i);
   assign consume = valid_q && bus.rdi_ready_i;
`ifdef RDI_LFSR_WHITEN_EN
   if (RND_W != 64) begin : g_bad_whiten_w
      $error("whitening requires RND_W = 64");
   end
   logic [63:0] mask;
   xoodoo_rdi_lfsr u_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (bus.flush_i),
      .step_i  (accept),
      .state_o (mask)
   );
   assign word = bus.rnd_i ^ mask;
`else
   assign word = bus.rnd_i;
`endif
   // transfer and accept are exclusive: transfer needs a full fill register
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         fill_q <= '0;
         out_q <= '0;
         cnt_q <= '0;
         valid_q <= 1'b0;
      end else if (bus.flush_i) begin
         fill_q <= '0;
         out_q <= '0;
         cnt_q <= '0;
         valid_q <= 1'b0;
      end else begin
         if (accept) begin
            fill_q[RND_W*cnt_q +: RND_W] <= word;
            cnt_q <= cnt_q + 4'd1;
         end
         if (transfer) begin
            out_q <= fill_q;
            cnt_q <= '0;
            valid_q <= 1'b1;
         end else if (consume) begin
            out_q <= '0;
            valid_q <= 1'b0;
         end
      end
   assign bus.rs0_o = out_q[XOODOO_STATE_W-1:0];
   assign bus.rs1_o = out_q[RDI_BLOCK_W-1:XOODOO_STATE_W];
   assign bus.rdi_valid_o = valid_q;
   assign bus.fill_level_o = cnt_q;
endmodule

// File: tb/tb_xoodoo_rdi_buffer.sv
// tb_xoodoo_rdi_buffer: directed and randomized checks of the mask buffer
// against a queue-based block model; honours RDI_LFSR_WHITEN_EN.
module tb_xoodoo_rdi_buffer;
   import xoodoo_rdi_buffer_pkg::*;
   localparam int NW = 12;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [63:0] fill_m[$];
   logic [767:0] out_m = '0;
   logic valid_m = 1'b0;
   logic [63:0] lfsr_m = RDI_LFSR_SEED;

   xoodoo_rdi_buffer_if #(.RND_W(64)) bus ();
   xoodoo_rdi_buffer #(.RND_W(64)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_lfsr(input logic [63:0] s);
      int taps[4] = '{64, 63, 61, 60};
      logic fb = 1'b0;
      foreach (taps[i]) fb ^= s[taps[i]-1];
      return {s[62:0], fb};
   endfunction

   task automatic model_clear();
      fill_m.delete();
      out_m = '0;
      valid_m = 1'b0;
      lfsr_m = RDI_LFSR_SEED;
   endtask

   task automatic check_state(input string tag);
      check({tag, ":valid"}, 768'(bus.rdi_valid_o), 768'(valid_m));
      check({tag, ":block"}, {bus.rs1_o, bus.rs0_o}, out_m);
      check({tag, ":level"}, 768'(bus.fill_level_o), 768'(fill_m.size()));
   endtask

   // one clock: drive, check ready, advance model over the edge, check state
   task automatic step(input logic fl, input logic v, input logic [63:0] w, input logic r);
      logic acc;
      logic [767:0] blk;
      bus.flush_i = fl;
      bus.rnd_valid_i = v;
      bus.rnd_i = w;
      bus.rdi_ready_i = r;
      #1;
      acc = (fill_m.size() < NW) && !fl;
      check("rnd_ready", 768'(bus.rnd_ready_o), 768'(acc));
      acc = acc && v;
      @(posedge clk);
      if (fl) model_clear();
      else begin
         if (fill_m.size() == NW && (!valid_m || r)) begin
            blk = '0;
            foreach (fill_m[i]) blk[64*i +: 64] = fill_m[i];
            out_m = blk;
            valid_m = 1'b1;
            fill_m.delete();
         end else if (valid_m && r) begin
            out_m = '0;
            valid_m = 1'b0;
         end
         if (acc) begin
`ifdef RDI_LFSR_WHITEN_EN
            fill_m.push_back(w ^ lfsr_m);
            lfsr_m = ref_lfsr(lfsr_m);
`else
            fill_m.push_back(w);
`endif
         end
      end
      #1;
      check_state("step");
   endtask

   task automatic send(input logic [63:0] base, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 64'(i), 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      check_state("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.flush_i = 1'b0;
      bus.rnd_valid_i = 1'b0;
      bus.rnd_i = '0;
      bus.rdi_ready_i = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
`ifdef RDI_LFSR_WHITEN_EN
      for (int i = 0; i < NW; i++) step(1'b0, 1'b1, 64'h0, 1'b0);
      step(1'b0, 1'b0, 64'h0, 1'b0);
      check("lfsr_seed", 768'(bus.rs0_o[63:0]), 768'(RDI_LFSR_SEED));
      check("lfsr_w1", 768'(bus.rs0_o[127:64]), 768'(ref_lfsr(RDI_LFSR_SEED)));
      step(1'b0, 1'b0, 64'h0, 1'b1);
`endif
      send(64'h1, NW);
      check("fill_full", 768'(bus.rdi_valid_o), 768'(0));
      step(1'b0, 1'b0, 64'h0, 1'b0);
      check("first_valid", 768'(bus.rdi_valid_o), 768'(1));
      check("ready_after_xfer", 768'(bus.rnd_ready_o), 768'(1));
`ifndef RDI_LFSR_WHITEN_EN
      check("w0_rs0", 768'(bus.rs0_o[63:0]), 768'(64'h1));
      check("w11_rs1", 768'(bus.rs1_o[383:320]), 768'(64'hC));
`endif
      send(64'h101, NW);
      step(1'b0, 1'b0, 64'h0, 1'b0);
      check("held_level", 768'(bus.fill_level_o), 768'(12));
      check("held_ready", 768'(bus.rnd_ready_o), 768'(0));
      step(1'b0, 1'b0, 64'h0, 1'b1);
      check("no_bubble", 768'(bus.rdi_valid_o), 768'(1));
`ifndef RDI_LFSR_WHITEN_EN
      check("second_w0", 768'(bus.rs0_o[63:0]), 768'(64'h101));
`endif
      send(64'h201, 5);
      step(1'b0, 1'b0, 64'h0, 1'b1);
      check("consume_valid", 768'(bus.rdi_valid_o), 768'(0));
      check("consume_zero", {bus.rs1_o, bus.rs0_o}, 768'(0));
      check("consume_level", 768'(bus.fill_level_o), 768'(5));
      step(1'b0, 1'b0, 64'h0, 1'b1);
      send(64'h301, 2);
      do_reset();
      send(64'hA, NW);
      step(1'b0, 1'b0, 64'h0, 1'b0);
      check("post_reset_valid", 768'(bus.rdi_valid_o), 768'(1));
`ifndef RDI_LFSR_WHITEN_EN
      check("post_reset_w0", 768'(bus.rs0_o[63:0]), 768'(64'hA));
      check("post_reset_w11", 768'(bus.rs1_o[383:320]), 768'(64'h15));
`endif
      send(64'h401, NW);
      check("pre_flush_level", 768'(bus.fill_level_o), 768'(12));
      step(1'b1, 1'b1, 64'hDEAD, 1'b1);
      check("flush_level", 768'(bus.fill_level_o), 768'(0));
      check("flush_valid", 768'(bus.rdi_valid_o), 768'(0));
      check("flush_block", {bus.rs1_o, bus.rs0_o}, 768'(0));
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                   {$urandom, $urandom}, $urandom_range(0, 2) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
